// File: rtl/alu1_pkg.sv
// Shared definitions for the alu1 issue sequencer and its 6-bit ALU datapath.
// Holds the opcode map, FSM state encoding and instruction field layout.
package alu1_pkg;

  localparam int DW = 6;

  localparam logic [1:0] OP_INC_ADD = 2'b00;
  localparam logic [1:0] OP_PASS    = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_SUB     = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    READ = 2'b01,
    EXEC = 2'b10,
    DONE = 2'b11
  } state_e;

  // Field order matches instr[7:0] = {op, rd, ra, rb}.
  typedef struct packed {
    logic [1:0] op;
    logic [1:0] rd;
    logic [1:0] ra;
    logic [1:0] rb;
  } instr_t;

endpackage

// File: rtl/alu1.sv
// 6-bit combinational ALU: a+b+1, pass a, a&b, a-b, all modulo 64.
// Zero latency, no handshake.
module alu1
  import alu1_pkg::*;
(
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic [1:0]    op_i,
  output logic [DW-1:0] f_o
);

  always_comb begin
    f_o = '0;
    case (op_i)
      OP_INC_ADD: f_o = a_i + b_i + DW'(1);
      OP_PASS:    f_o = a_i;
      OP_AND:     f_o = a_i & b_i;
      OP_SUB:     f_o = a_i - b_i;
      default:    f_o = '0;
    endcase
  end

endmodule

// File: rtl/alu1_seq.sv
// Issue sequencer for alu1: IDLE->READ->EXEC->DONE, result valid 2 edges after accept.
// in_ready only in IDLE; DONE holds the result until out_ready is sampled high.
module alu1_seq
  import alu1_pkg::*;
#(
  parameter int NREG = 4,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      instr,
  input  logic            wr_en,
  input  logic [1:0]      wr_addr,
  input  logic [DW-1:0]   wr_data,
  input  logic [1:0]      rd_addr,
  output logic [DW-1:0]   rd_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   res,
  output logic            res_zero,
  output logic            res_neg,
  output logic [CNTW-1:0] ops_done
);

  state_e          state_q, state_d;
  instr_t          instr_q;
  logic [DW-1:0]   opa_q, opb_q;
  logic [DW-1:0]   res_q;
  logic            zero_q, neg_q;
  logic [CNTW-1:0] ops_done_q;
  logic [DW-1:0]   regs_q [NREG];
  logic [DW-1:0]   regs_d [NREG];
  logic [DW-1:0]   alu_f;

  alu1 u_alu (
    .a_i  (opa_q),
    .b_i  (opb_q),
    .op_i (instr_q.op),
    .f_o  (alu_f)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = READ;
      READ:    state_d = EXEC;
      EXEC:    state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Writeback is applied after the direct write so it wins on a collision.
  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[wr_addr] = wr_data;
    if (state_q == EXEC) regs_d[instr_q.rd] = alu_f;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      instr_q    <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      res_q      <= '0;
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
      ops_done_q <= '0;
    end else begin
      regs_q <= regs_d;
      if (state_q == IDLE && in_valid) instr_q <= instr_t'(instr);
      if (state_q == READ) begin
        opa_q <= regs_q[instr_q.ra];
        opb_q <= regs_q[instr_q.rb];
      end
      if (state_q == EXEC) begin
        res_q      <= alu_f;
        zero_q     <= (alu_f == '0);
        neg_q      <= alu_f[DW-1];
        ops_done_q <= ops_done_q + CNTW'(1);
      end
    end
  end

  assign rd_data  = regs_q[rd_addr];
  assign res      = res_q;
  assign res_zero = zero_q;
  assign res_neg  = neg_q;
  assign ops_done = ops_done_q;

endmodule

// File: tb/tb_alu1_seq.sv
// Directed-vector bench for alu1_seq with hand-computed expectations.
module tb_alu1_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] instr;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [5:0] wr_data;
  logic [1:0] rd_addr;
  logic [5:0] rd_data;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] res;
  logic       res_zero;
  logic       res_neg;
  logic [7:0] ops_done;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu1_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .res_zero  (res_zero),
    .res_neg   (res_neg),
    .ops_done  (ops_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [1:0] a, input logic [5:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  // Presents one instruction for exactly the accepting edge.
  task automatic accept(input logic [7:0] i);
    in_valid = 1'b1; instr = i;
    step();
    in_valid = 1'b0; instr = 8'hFF;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; instr = 8'h00; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 6'd0;
    rd_addr = 2'd0; out_ready = 1'b0;
    step(); step();
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (res !== 6'd0) begin n_fail++; $display("FAIL reset_res got=%0d exp=0", res); end
    n_cmp++; if ({res_zero, res_neg} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got=%b exp=00", {res_zero, res_neg}); end
    n_cmp++; if (ops_done !== 8'd0) begin n_fail++; $display("FAIL reset_ops_done got=%0d exp=0", ops_done); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_add();
    preload(2'd0, 6'd5);
    preload(2'd1, 6'd3);
    out_ready = 1'b1;
    accept(8'b00_10_00_01);
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL add_in_ready_read got=%b exp=0", in_ready); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_out_valid_exec got=%b exp=0", out_valid); end
    step();
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_out_valid got=%b exp=1", out_valid); end
    n_cmp++; if (res !== 6'd9) begin n_fail++; $display("FAIL add_res got=%0d exp=9", res); end
    n_cmp++; if ({res_zero, res_neg} !== 2'b00) begin n_fail++; $display("FAIL add_flags got=%b exp=00", {res_zero, res_neg}); end
    n_cmp++; if (ops_done !== 8'd1) begin n_fail++; $display("FAIL add_ops_done got=%0d exp=1", ops_done); end
    rd_addr = 2'd2; #1;
    n_cmp++; if (rd_data !== 6'd9) begin n_fail++; $display("FAIL add_r2 got=%0d exp=9", rd_data); end
    step();
    n_cmp++; if ({in_ready, out_valid} !== 2'b10) begin n_fail++; $display("FAIL add_return_idle got=%b exp=10", {in_ready, out_valid}); end
  endtask

  task automatic test_sub();
    preload(2'd0, 6'd3);
    preload(2'd1, 6'd5);
    accept(8'b11_11_00_01);
    step(); step();
    n_cmp++; if (res !== 6'd62) begin n_fail++; $display("FAIL sub_res got=%0d exp=62", res); end
    n_cmp++; if ({res_zero, res_neg} !== 2'b01) begin n_fail++; $display("FAIL sub_flags got=%b exp=01", {res_zero, res_neg}); end
    rd_addr = 2'd3; #1;
    n_cmp++; if (rd_data !== 6'd62) begin n_fail++; $display("FAIL sub_r3 got=%0d exp=62", rd_data); end
    step();
  endtask

  task automatic test_and_pass();
    preload(2'd0, 6'h2A);
    preload(2'd1, 6'h0F);
    accept(8'b10_00_00_01);
    step(); step();
    n_cmp++; if (res !== 6'h0A) begin n_fail++; $display("FAIL and_res got=%0h exp=a", res); end
    rd_addr = 2'd0; #1;
    n_cmp++; if (rd_data !== 6'h0A) begin n_fail++; $display("FAIL and_r0 got=%0h exp=a", rd_data); end
    step();
    preload(2'd2, 6'd17);
    accept(8'b01_01_10_11);
    step(); step();
    n_cmp++; if (res !== 6'd17) begin n_fail++; $display("FAIL pass_res got=%0d exp=17", res); end
    n_cmp++; if (ops_done !== 8'd4) begin n_fail++; $display("FAIL pass_ops_done got=%0d exp=4", ops_done); end
    rd_addr = 2'd1; #1;
    n_cmp++; if (rd_data !== 6'd17) begin n_fail++; $display("FAIL pass_r1 got=%0d exp=17", rd_data); end
    step();
  endtask

  task automatic test_wrap_zero();
    preload(2'd0, 6'd31);
    accept(8'b00_01_00_00);
    step(); step();
    n_cmp++; if (res !== 6'd63) begin n_fail++; $display("FAIL wrap_res got=%0d exp=63", res); end
    n_cmp++; if ({res_zero, res_neg} !== 2'b01) begin n_fail++; $display("FAIL wrap_flags got=%b exp=01", {res_zero, res_neg}); end
    step();
    preload(2'd2, 6'd5);
    accept(8'b11_11_10_10);
    step(); step();
    n_cmp++; if (res !== 6'd0) begin n_fail++; $display("FAIL zero_res got=%0d exp=0", res); end
    n_cmp++; if ({res_zero, res_neg} !== 2'b10) begin n_fail++; $display("FAIL zero_flags got=%b exp=10", {res_zero, res_neg}); end
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    preload(2'd0, 6'd1);
    preload(2'd1, 6'd2);
    accept(8'b00_10_00_01);
    step(); step();
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; instr = 8'b11_00_01_00;
      step();
      n_cmp++; if ({out_valid, in_ready} !== 2'b10) begin n_fail++; $display("FAIL bp_hs cyc=%0d got=%b exp=10", k, {out_valid, in_ready}); end
      n_cmp++; if ({res, res_zero, res_neg} !== {6'd4, 2'b00}) begin n_fail++; $display("FAIL bp_res cyc=%0d got=%0d exp=4", k, res); end
    end
    in_valid = 1'b0;
    n_cmp++; if (ops_done !== 8'd7) begin n_fail++; $display("FAIL bp_ops_hold got=%0d exp=7", ops_done); end
    out_ready = 1'b1;
    step();
    n_cmp++; if ({in_ready, out_valid} !== 2'b10) begin n_fail++; $display("FAIL bp_release got=%b exp=10", {in_ready, out_valid}); end
    n_cmp++; if (ops_done !== 8'd7) begin n_fail++; $display("FAIL bp_ops_done got=%0d exp=7", ops_done); end
    rd_addr = 2'd0; #1;
    n_cmp++; if (rd_data !== 6'd1) begin n_fail++; $display("FAIL bp_ignored_instr r0 got=%0d exp=1", rd_data); end
  endtask

  task automatic test_conflict();
    preload(2'd0, 6'd4);
    preload(2'd1, 6'd1);
    accept(8'b00_10_00_01);
    // Write during READ is not seen by the operand latch.
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 6'd20;
    step();
    wr_addr = 2'd2; wr_data = 6'd7;
    step();
    wr_en = 1'b0;
    n_cmp++; if (res !== 6'd6) begin n_fail++; $display("FAIL conflict_res got=%0d exp=6", res); end
    rd_addr = 2'd2; #1;
    n_cmp++; if (rd_data !== 6'd6) begin n_fail++; $display("FAIL conflict_r2 got=%0d exp=6", rd_data); end
    rd_addr = 2'd0; #1;
    n_cmp++; if (rd_data !== 6'd20) begin n_fail++; $display("FAIL conflict_r0 got=%0d exp=20", rd_data); end
    step();
  endtask

  task automatic test_reset_mid();
    preload(2'd0, 6'd9);
    accept(8'b00_01_00_00);
    rst = 1'b1; #1;
    n_cmp++; if ({in_ready, out_valid} !== 2'b10) begin n_fail++; $display("FAIL rstmid_hs got=%b exp=10", {in_ready, out_valid}); end
    n_cmp++; if (ops_done !== 8'd0) begin n_fail++; $display("FAIL rstmid_ops_done got=%0d exp=0", ops_done); end
    for (int r = 0; r < 4; r++) begin
      rd_addr = 2'(r); #1;
      n_cmp++; if (rd_data !== 6'd0) begin n_fail++; $display("FAIL rstmid_reg r%0d got=%0d exp=0", r, rd_data); end
    end
    step();
    rst = 1'b0;
    step(); step(); step();
    rd_addr = 2'd1; #1;
    n_cmp++; if ({in_ready, out_valid, rd_data} !== {2'b10, 6'd0}) begin n_fail++; $display("FAIL rstmid_no_wb got=%b exp=10_000000", {in_ready, out_valid, rd_data}); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_and_pass();
    test_wrap_zero();
    test_backpressure();
    test_conflict();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
